// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: per-stage ready/flush,
// ID branch forward selects, exception drain/redirect FSM and a stall-cycle counter.
//
// state       | meaning
// S_RUN       | normal issue; resolves memory wait, hazards and exception entry
// S_WAIT_MEM  | data memory access outstanding, IF..MEM held, WB gets bubbles
// S_EXC_DRAIN | IF/ID held while EX/MEM/WB retire before the redirect
// S_EXC_REDIR | one cycle: IF loads vector/EPC, IF and ID squashed
module pipeline_ctrl #(
  parameter int EXC_DRAIN = 3,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_bj,
  input  logic [4:0]       ex_dst,
  input  logic             ex_we,
  input  logic             ex_load,
  input  logic [4:0]       mem_dst,
  input  logic             mem_we,
  input  logic             mem_load,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             exc_req,
  output logic [4:0]       stage_ready,
  output logic [4:0]       stage_flush,
  output logic             fwd_rs_bj,
  output logic             fwd_rt_bj,
  output logic             pc_redirect,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {S_RUN, S_WAIT_MEM, S_EXC_DRAIN, S_EXC_REDIR} state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(EXC_DRAIN - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       ret_drain, ret_drain_nxt;

  function automatic logic match(input logic [4:0] r, input logic [4:0] dst, input logic we);
    return we && (dst == r) && (r != 5'd0);
  endfunction

  logic ex_rs, ex_rt, ml_rs, ml_rt;
  logic haz_rs, haz_rt, hazard, mem_stall, wait_cond;

  assign ex_rs = match(id_rs, ex_dst, ex_we);
  assign ex_rt = match(id_rt, ex_dst, ex_we);
  assign ml_rs = match(id_rs, mem_dst, mem_we);
  assign ml_rt = match(id_rt, mem_dst, mem_we);

  // EX results are never visible to an ID-resolved branch; MEM loads are not forwardable either.
  assign haz_rs = id_use_rs & ((ex_rs & ex_load) | (id_bj & ex_rs) | (id_bj & ml_rs & mem_load));
  assign haz_rt = id_use_rt & ((ex_rt & ex_load) | (id_bj & ex_rt) | (id_bj & ml_rt & mem_load));
  assign hazard = haz_rs | haz_rt;

  assign mem_stall = mem_req & ~mem_ack;
  assign wait_cond = (state == S_WAIT_MEM) ? ~mem_ack : mem_stall;

  assign fwd_rs_bj = rst_n & id_bj & ml_rs & ~mem_load;
  assign fwd_rt_bj = rst_n & id_bj & ml_rt & ~mem_load;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    ret_drain_nxt = ret_drain;
    stage_ready   = 5'b11111;
    stage_flush   = 5'b00000;
    pc_redirect   = 1'b0;
    unique case (state)
      S_RUN, S_WAIT_MEM: begin
        if (wait_cond) begin
          stage_ready = 5'b10000;
          stage_flush = 5'b10000;
          state_nxt   = S_WAIT_MEM;
          if (state == S_RUN) ret_drain_nxt = 1'b0;
        end else if (state == S_WAIT_MEM && ret_drain) begin
          stage_ready   = 5'b11100;
          stage_flush   = 5'b00100;
          state_nxt     = S_EXC_DRAIN;
          ret_drain_nxt = 1'b0;
        end else if (hazard) begin
          stage_ready = 5'b11100;
          stage_flush = 5'b00100;
          state_nxt   = S_RUN;
        end else if (exc_req) begin
          stage_ready = 5'b11100;
          stage_flush = 5'b00100;
          cnt_nxt     = DRAIN_LOAD;
          state_nxt   = S_EXC_DRAIN;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_EXC_DRAIN: begin
        if (mem_stall) begin
          stage_ready   = 5'b10000;
          stage_flush   = 5'b10000;
          state_nxt     = S_WAIT_MEM;
          ret_drain_nxt = 1'b1;
        end else begin
          stage_ready = 5'b11100;
          stage_flush = 5'b00100;
          if (cnt == 4'd0) state_nxt = S_EXC_REDIR;
          else             cnt_nxt   = cnt - 4'd1;
        end
      end
      S_EXC_REDIR: begin
        pc_redirect = 1'b1;
        stage_flush = 5'b00011;
        state_nxt   = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
    if (!rst_n) begin
      stage_ready = 5'b11111;
      stage_flush = 5'b11111;
      pc_redirect = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_RUN;
      cnt          <= 4'd0;
      ret_drain    <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ret_drain <= ret_drain_nxt;
      if (!stage_ready[1] && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl; a second narrow-counter instance
// shares the stimulus to exercise stall counter saturation.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_dst, mem_dst;
  logic        id_use_rs, id_use_rt, id_bj, ex_we, ex_load, mem_we, mem_load;
  logic        mem_req, mem_ack, exc_req;
  logic [4:0]  stage_ready, stage_flush;
  logic        fwd_rs_bj, fwd_rt_bj, pc_redirect;
  logic [31:0] stall_cycles;
  logic [4:0]  ready_s, flush_s;
  logic        fwd_rs_s, fwd_rt_s, pc_s;
  logic [1:0]  stall_s;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.EXC_DRAIN(3), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_bj(id_bj), .ex_dst(ex_dst), .ex_we(ex_we), .ex_load(ex_load),
    .mem_dst(mem_dst), .mem_we(mem_we), .mem_load(mem_load), .mem_req(mem_req),
    .mem_ack(mem_ack), .exc_req(exc_req), .stage_ready(stage_ready), .stage_flush(stage_flush),
    .fwd_rs_bj(fwd_rs_bj), .fwd_rt_bj(fwd_rt_bj), .pc_redirect(pc_redirect),
    .stall_cycles(stall_cycles)
  );

  pipeline_ctrl #(.EXC_DRAIN(3), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_bj(id_bj), .ex_dst(ex_dst), .ex_we(ex_we), .ex_load(ex_load),
    .mem_dst(mem_dst), .mem_we(mem_we), .mem_load(mem_load), .mem_req(mem_req),
    .mem_ack(mem_ack), .exc_req(exc_req), .stage_ready(ready_s), .stage_flush(flush_s),
    .fwd_rs_bj(fwd_rs_s), .fwd_rt_bj(fwd_rt_s), .pc_redirect(pc_s), .stall_cycles(stall_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_bj = 0;
    ex_dst = 0; ex_we = 0; ex_load = 0; mem_dst = 0; mem_we = 0; mem_load = 0;
    mem_req = 0; mem_ack = 0; exc_req = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    id_bj = 1; id_rt = 9; id_use_rt = 1; mem_dst = 9; mem_we = 1;
    #1;
    checks++; if (stage_ready !== 5'b11111) begin errors++; $display("FAIL rst_ready: got %b expected 11111", stage_ready); end
    checks++; if (stage_flush !== 5'b11111) begin errors++; $display("FAIL rst_flush: got %b expected 11111", stage_flush); end
    checks++; if (fwd_rt_bj !== 1'b0) begin errors++; $display("FAIL rst_fwd: got %b expected 0", fwd_rt_bj); end
    checks++; if (pc_redirect !== 1'b0) begin errors++; $display("FAIL rst_pc: got %b expected 0", pc_redirect); end
    tick();
    tick();
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rst_stall: got %0d expected 0", stall_cycles); end
    rst_n = 1;
    clear_inputs();
    #1;
    checks++; if (stage_ready !== 5'b11111 || stage_flush !== 5'b00000) begin errors++; $display("FAIL rst_release: got %b/%b expected 11111/00000", stage_ready, stage_flush); end
    tick();
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rst_idle_stall: got %0d expected 0", stall_cycles); end
  endtask

  task automatic test_load_use();
    ex_load = 1; ex_we = 1; ex_dst = 5; id_rs = 5; id_use_rs = 1;
    #1;
    checks++; if (stage_ready !== 5'b11100 || stage_flush !== 5'b00100) begin errors++; $display("FAIL lu_stall: got %b/%b expected 11100/00100", stage_ready, stage_flush); end
    tick(); exp_stall = 1;
    checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL lu_count: got %0d expected %0d", stall_cycles, exp_stall); end
    ex_load = 0;
    #1;
    checks++; if (stage_ready !== 5'b11111 || stage_flush !== 5'b00000) begin errors++; $display("FAIL lu_release: got %b/%b expected 11111/00000", stage_ready, stage_flush); end
    tick();
    clear_inputs();
    ex_load = 1; ex_we = 1; ex_dst = 7; id_rt = 7; id_use_rt = 0;
    #1;
    checks++; if (stage_ready !== 5'b11111) begin errors++; $display("FAIL lu_unused_rt: got %b expected 11111", stage_ready); end
    id_use_rt = 1;
    #1;
    checks++; if (stage_ready !== 5'b11100) begin errors++; $display("FAIL lu_rt: got %b expected 11100", stage_ready); end
    tick(); exp_stall++;
    clear_inputs();
  endtask

  task automatic test_zero_reg();
    ex_load = 1; ex_we = 1; ex_dst = 0; id_rs = 0; id_use_rs = 1;
    #1;
    checks++; if (stage_ready !== 5'b11111 || stage_flush !== 5'b00000) begin errors++; $display("FAIL zero_reg: got %b/%b expected 11111/00000", stage_ready, stage_flush); end
    tick();
    checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL zero_count: got %0d expected %0d", stall_cycles, exp_stall); end
    clear_inputs();
  endtask

  task automatic test_branch_fwd();
    id_bj = 1; id_rt = 9; id_use_rt = 1; mem_dst = 9; mem_we = 1; mem_load = 0;
    #1;
    checks++; if (fwd_rt_bj !== 1'b1 || fwd_rs_bj !== 1'b0) begin errors++; $display("FAIL bj_fwd: got rs=%b rt=%b expected rs=0 rt=1", fwd_rs_bj, fwd_rt_bj); end
    checks++; if (stage_ready !== 5'b11111) begin errors++; $display("FAIL bj_fwd_ready: got %b expected 11111", stage_ready); end
    tick();
    mem_load = 1;
    #1;
    checks++; if (fwd_rt_bj !== 1'b0 || stage_ready !== 5'b11100) begin errors++; $display("FAIL bj_memload: got fwd=%b ready=%b expected fwd=0 ready=11100", fwd_rt_bj, stage_ready); end
    tick(); exp_stall++;
    clear_inputs();
    id_bj = 1; id_rs = 3; id_use_rs = 1; ex_dst = 3; ex_we = 1;
    #1;
    checks++; if (stage_ready !== 5'b11100 || stage_flush !== 5'b00100) begin errors++; $display("FAIL bj_ex: got %b/%b expected 11100/00100", stage_ready, stage_flush); end
    tick(); exp_stall++;
    id_bj = 0;
    #1;
    checks++; if (stage_ready !== 5'b11111) begin errors++; $display("FAIL nonbj_ex: got %b expected 11111", stage_ready); end
    tick();
    checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL bj_count: got %0d expected %0d", stall_cycles, exp_stall); end
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    mem_req = 1; mem_ack = 0;
    ex_load = 1; ex_we = 1; ex_dst = 5; id_rs = 5; id_use_rs = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (stage_ready !== 5'b10000 || stage_flush !== 5'b10000) begin errors++; $display("FAIL memwait_%0d: got %b/%b expected 10000/10000", i, stage_ready, stage_flush); end
      tick(); exp_stall++;
    end
    mem_ack = 1;
    #1;
    checks++; if (stage_ready !== 5'b11100 || stage_flush !== 5'b00100) begin errors++; $display("FAIL memack_lu: got %b/%b expected 11100/00100", stage_ready, stage_flush); end
    tick(); exp_stall++;
    clear_inputs();
    #1;
    checks++; if (stage_ready !== 5'b11111) begin errors++; $display("FAIL memwait_done: got %b expected 11111", stage_ready); end
    tick();
    checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL memwait_count: got %0d expected %0d", stall_cycles, exp_stall); end
    checks++; if (stall_s !== ((exp_stall > 3) ? 2'd3 : 2'(exp_stall))) begin errors++; $display("FAIL stall_sat: got %0d expected 3", stall_s); end
    mem_req = 1; mem_ack = 1;
    #1;
    checks++; if (stage_ready !== 5'b11111) begin errors++; $display("FAIL mem_ack_same: got %b expected 11111", stage_ready); end
    tick();
    clear_inputs();
  endtask

  task automatic test_exception();
    exc_req = 1; ex_load = 1; ex_we = 1; ex_dst = 4; id_rt = 4; id_use_rt = 1;
    #1;
    checks++; if (stage_ready !== 5'b11100) begin errors++; $display("FAIL exc_blocked: got %b expected 11100", stage_ready); end
    tick(); exp_stall++;
    clear_inputs();
    #1;
    checks++; if (stage_ready !== 5'b11111 || pc_redirect !== 1'b0) begin errors++; $display("FAIL exc_dropped: got %b pc=%b expected 11111 pc=0", stage_ready, pc_redirect); end
    tick();
    exc_req = 1;
    #1;
    checks++; if (stage_ready !== 5'b11100 || stage_flush !== 5'b00100) begin errors++; $display("FAIL exc_entry: got %b/%b expected 11100/00100", stage_ready, stage_flush); end
    tick(); exp_stall++;
    exc_req = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stage_ready !== 5'b11100 || pc_redirect !== 1'b0) begin errors++; $display("FAIL exc_drain_%0d: got %b pc=%b expected 11100 pc=0", i, stage_ready, pc_redirect); end
      tick(); exp_stall++;
    end
    #1;
    checks++; if (pc_redirect !== 1'b1 || stage_ready !== 5'b11111 || stage_flush !== 5'b00011) begin errors++; $display("FAIL exc_redir: got pc=%b %b/%b expected pc=1 11111/00011", pc_redirect, stage_ready, stage_flush); end
    tick();
    #1;
    checks++; if (pc_redirect !== 1'b0 || stage_ready !== 5'b11111 || stage_flush !== 5'b00000) begin errors++; $display("FAIL exc_back_run: got pc=%b %b/%b expected pc=0 11111/00000", pc_redirect, stage_ready, stage_flush); end
    tick();
    checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL exc_count: got %0d expected %0d", stall_cycles, exp_stall); end
  endtask

  task automatic test_exc_mem_wait();
    logic [4:0] er [9];
    logic [4:0] ef [9];
    logic       ep [9];
    logic       mq [9];
    logic       ma [9];
    er = '{5'b11100, 5'b11100, 5'b10000, 5'b10000, 5'b11100, 5'b11100, 5'b11100, 5'b11111, 5'b11111};
    ef = '{5'b00100, 5'b00100, 5'b10000, 5'b10000, 5'b00100, 5'b00100, 5'b00100, 5'b00011, 5'b00000};
    ep = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    mq = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
    ma = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      exc_req = (i == 0); mem_req = mq[i]; mem_ack = ma[i];
      #1;
      checks++; if (stage_ready !== er[i] || stage_flush !== ef[i] || pc_redirect !== ep[i]) begin errors++; $display("FAIL excmem_%0d: got %b/%b pc=%b expected %b/%b pc=%b", i, stage_ready, stage_flush, pc_redirect, er[i], ef[i], ep[i]); end
      tick();
      if (!er[i][1]) exp_stall++;
    end
    clear_inputs();
    checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL excmem_count: got %0d expected %0d", stall_cycles, exp_stall); end
  endtask

  task automatic test_reset_mid_drain();
    exc_req = 1;
    tick();
    exc_req = 0;
    tick();
    rst_n = 0;
    #1;
    checks++; if (stage_ready !== 5'b11111 || stage_flush !== 5'b11111 || pc_redirect !== 1'b0) begin errors++; $display("FAIL rstdrain_out: got %b/%b pc=%b expected 11111/11111 pc=0", stage_ready, stage_flush, pc_redirect); end
    tick();
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rstdrain_stall: got %0d expected 0", stall_cycles); end
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (stage_ready !== 5'b11111 || stage_flush !== 5'b00000 || pc_redirect !== 1'b0) begin errors++; $display("FAIL rstdrain_run_%0d: got %b/%b pc=%b expected 11111/00000 pc=0", i, stage_ready, stage_flush, pc_redirect); end
      tick();
    end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rstdrain_after: got %0d expected 0", stall_cycles); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch_fwd();
    test_mem_wait();
    test_exception();
    test_exc_mem_wait();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB). It drives per-stage PIPELINE_READY/PIPELINE_FLUSH pairs and the ID-stage branch/jump forward selects. It resolves load-use and branch-operand hazards, data-memory wait, and syscall/eret drain-and-redirect with a small FSM. It also keeps a stall-cycle performance counter.

Parameters:
EXC_DRAIN, 3, cycles to let EX/MEM/WB retire before an exception redirect (1..15)
CNT_W, 32, width of stall_cycles counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
id_rs  in  5  rs index of instruction in ID
id_rt  in  5  rt index of instruction in ID
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_bj  in  1  ID instruction is branch/jump resolving operands in ID
ex_dst  in  5  EX destination register
ex_we  in  1  EX writes a register
ex_load  in  1  EX is a load
mem_dst  in  5  MEM destination register
mem_we  in  1  MEM writes a register
mem_load  in  1  MEM is a load
mem_req  in  1  MEM stage has a data access in flight
mem_ack  in  1  data memory completes access this cycle
exc_req  in  1  syscall/eret decoded in ID (level, valid while in ID)
stage_ready  out  5  bit i = stage i captures its input (0 IF .. 4 WB)
stage_flush  out  5  bit i = stage i loads a bubble when its ready is 1
fwd_rs_bj  out  1  ID branch rs operand taken from MEM forward path
fwd_rt_bj  out  1  ID branch rt operand taken from MEM forward path
pc_redirect  out  1  one-cycle pulse: IF loads exception vector / EPC
stall_cycles  out  CNT_W  count of cycles with stage_ready[1]=0

Behaviour:
- Reset (rst_n=0 at clk edge): state RUN, drain counter 0, stall_cycles 0. While rst_n=0: stage_ready=5'b11111, stage_flush=5'b11111, fwd_*=0, pc_redirect=0.
- Match(r, dst, we) = we & (dst==r) & (r!=0); register $0 never hazards.
- Hazard terms, per operand x in {rs,rt} gated by id_use_x:
  lu = Match(x, ex_dst, ex_we) & ex_load.
  bj_ex = id_bj & Match(x, ex_dst, ex_we) (any EX result; not yet available to ID).
  bj_ml = id_bj & Match(x, mem_dst, mem_we) & mem_load.
- fwd_x_bj = id_bj & Match(x, mem_dst, mem_we) & ~mem_load (combinational, all states, 0 in reset).
- States: RUN, WAIT_MEM, EXC_DRAIN, EXC_REDIR.
- RUN, priority order:
  1. mem_req & ~mem_ack -> stage_ready=5'b10000, stage_flush=5'b10000 (WB bubble, IF..MEM hold); next WAIT_MEM.
  2. any lu|bj_ex|bj_ml -> stage_ready=5'b11100, stage_flush=5'b00100 (IF/ID hold, bubble into EX); stay RUN.
  3. exc_req -> stage_ready=5'b11100, stage_flush=5'b00100; load drain counter with EXC_DRAIN-1; next EXC_DRAIN.
  4. else stage_ready=5'b11111, stage_flush=0.
- WAIT_MEM: outputs as RUN rule 1 until mem_ack=1; on mem_ack cycle evaluate RUN rules 2-4 and leave per them (mem_ack cycle is not a stall for memory). If returning from EXC_DRAIN, return to EXC_DRAIN with counter preserved (one-bit return flag).
- EXC_DRAIN: stage_ready=5'b11100, stage_flush=5'b00100; counter decrements each cycle; mem_req&~mem_ack -> WAIT_MEM (counter frozen); counter==0 -> EXC_REDIR.
- EXC_REDIR (1 cycle): pc_redirect=1, stage_ready=5'b11111, stage_flush=5'b00011 (squash IF and ID contents); next RUN.
- exc_req ignored outside RUN decision; load-use takes priority so exception waits for a clean ID.
- stall_cycles increments when stage_ready[1]=0 and rst_n=1; saturates at all-ones.
- All outputs except stall_cycles are combinational from state, counter and inputs; no output registers.

Test Plan:
- Load-use: ex_load=1, ex_we=1, ex_dst=5, id_rs=5, id_use_rs=1 one cycle -> stage_ready=11100, stage_flush=00100 that cycle, stall_cycles 0->1; next cycle (ex_load=0) ready=11111.
- $0 immunity: same as above with ex_dst=0, id_rs=0 -> ready=11111, no stall.
- Branch forward: id_bj=1, id_rt=9, mem_dst=9, mem_we=1, mem_load=0 -> fwd_rt_bj=1, ready=11111; set mem_load=1 -> fwd_rt_bj=0, ready=11100.
- Memory wait: mem_req=1, mem_ack low 4 cycles then high -> ready=10000/flush=10000 for 4 cycles, 11111 on ack cycle; stall_cycles=4.
- Exception, EXC_DRAIN=3: exc_req pulse in RUN -> 3 cycles ready=11100, then one cycle pc_redirect=1, flush=00011, then RUN; a 2-cycle mem wait injected mid-drain extends total to 6 cycles before redirect.
- Reset mid-drain: rst_n=0 during EXC_DRAIN -> ready=flush=11111, pc_redirect=0, stall_cycles=0; after release RUN with ready=11111.
